// File: rtl/multiplier_pkg.sv
// ---------------------------------------------------------------------------
// multiplier_pkg
//   Shared definitions for the Kyber multiply/reduce path.
//   - DATA_LENGTH : width of the unreduced product bus to the reducer
//   - KYBER_Q     : Kyber modulus q
//   - KYBER_BL    : bit length of a coefficient mod q
//   - mul_state_e : control states of the sequential shift-add multiplier
// ---------------------------------------------------------------------------
package multiplier_pkg;

  localparam int DATA_LENGTH = 32;
  localparam int KYBER_Q     = 3329;
  localparam int KYBER_BL    = 12;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/shiftadd_mul_step.sv
// ---------------------------------------------------------------------------
// shiftadd_mul_step
//   Combinational single-iteration datapath of the shift-add multiplier:
//   conditionally adds the shifted multiplicand into the accumulator, then
//   shifts the multiplicand left and the multiplier right.
//
//   Build option: SHIFTADD_MUL_RADIX4_EN
//     undefined : one multiplier bit per iteration (radix-2)
//     defined   : two multiplier bits per iteration (radix-4)
//
// Ports
//   acc        in   DATA_LENGTH  current accumulator
//   a_sh       in   DATA_LENGTH  current shifted multiplicand
//   b_sh       in   OP_WIDTH     current shifted multiplier
//   acc_next   out  DATA_LENGTH  accumulator after this iteration
//   a_sh_next  out  DATA_LENGTH  multiplicand after this iteration
//   b_sh_next  out  OP_WIDTH     multiplier after this iteration
// ---------------------------------------------------------------------------
module shiftadd_mul_step
  import multiplier_pkg::*;
#(
  parameter int OP_WIDTH = 12
) (
  input  logic [DATA_LENGTH-1:0] acc,
  input  logic [DATA_LENGTH-1:0] a_sh,
  input  logic [OP_WIDTH-1:0]    b_sh,
  output logic [DATA_LENGTH-1:0] acc_next,
  output logic [DATA_LENGTH-1:0] a_sh_next,
  output logic [OP_WIDTH-1:0]    b_sh_next
);

`ifdef SHIFTADD_MUL_RADIX4_EN
  // Partial product selected by the low multiplier digit: {0, a, 2a, 3a}.
  logic [DATA_LENGTH-1:0] addend;

  always_comb begin
    addend = '0;
    case (b_sh[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = a_sh;
      2'd2:    addend = a_sh << 1;
      default: addend = a_sh + (a_sh << 1);
    endcase
  end

  assign acc_next  = acc + addend;
  assign a_sh_next = a_sh << 2;
  assign b_sh_next = b_sh >> 2;
`else
  assign acc_next  = b_sh[0] ? (acc + a_sh) : acc;
  assign a_sh_next = a_sh << 1;
  assign b_sh_next = b_sh >> 1;
`endif

endmodule

// File: rtl/shiftadd_mul_seq.sv
// ---------------------------------------------------------------------------
// shiftadd_mul_seq
//   Sequential shift-add multiplier feeding the Kyber modular reducer.
//   Accepts an operand pair in IDLE, iterates in RUN (fixed latency, no early
//   exit), and presents the unreduced product in DONE until accepted.
//
//   Build option: SHIFTADD_MUL_RADIX4_EN (see shiftadd_mul_step). With it,
//   RUN lasts OP_WIDTH/2 cycles instead of OP_WIDTH; results are identical.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. valid_i is only looked at in IDLE (ready_o=1); ready_i is only
//   looked at in DONE (valid_o=1). The DONE->IDLE return takes one cycle, so
//   the next operand pair is accepted at the earliest one cycle later.
//
// Ports
//   clk_i      in   1            clock, rising edge
//   rst_i      in   1            asynchronous active-high reset
//   valid_i    in   1            operand pair valid
//   ready_o    out  1            block can accept operands (IDLE)
//   a_i        in   OP_WIDTH     multiplicand
//   b_i        in   OP_WIDTH     multiplier
//   valid_o    out  1            product valid (DONE)
//   ready_i    in   1            downstream accepts product
//   product_o  out  DATA_LENGTH  a*b zero-extended; holds last accumulator
//   busy_o     out  1            high while iterating (RUN)
// ---------------------------------------------------------------------------
module shiftadd_mul_seq
  import multiplier_pkg::*;
#(
  parameter int OP_WIDTH = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [OP_WIDTH-1:0]    a_i,
  input  logic [OP_WIDTH-1:0]    b_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_LENGTH-1:0] product_o,
  output logic                   busy_o
);

`ifdef SHIFTADD_MUL_RADIX4_EN
  localparam int ITER = OP_WIDTH / 2;
  if (OP_WIDTH % 2 != 0) begin : g_odd_width
    $error("shiftadd_mul_seq: OP_WIDTH must be even in the radix-4 build");
  end
`else
  localparam int ITER = OP_WIDTH;
`endif

  // The counter must hold ITER itself (value after the last increment).
  localparam int CNT_W = $clog2(ITER + 1);

  if (2 * OP_WIDTH > DATA_LENGTH) begin : g_too_wide
    $error("shiftadd_mul_seq: 2*OP_WIDTH exceeds DATA_LENGTH");
  end

  // State is kept as a named signal so checkers can observe it directly.
  mul_state_e state;
  mul_state_e state_next;

  logic [DATA_LENGTH-1:0] acc;
  logic [DATA_LENGTH-1:0] a_sh;
  logic [OP_WIDTH-1:0]    b_sh;
  logic [CNT_W-1:0]       cnt;

  logic [DATA_LENGTH-1:0] acc_step;
  logic [DATA_LENGTH-1:0] a_sh_step;
  logic [OP_WIDTH-1:0]    b_sh_step;

  logic accept;
  logic last_iter;

  shiftadd_mul_step #(
    .OP_WIDTH (OP_WIDTH)
  ) u_step (
    .acc       (acc),
    .a_sh      (a_sh),
    .b_sh      (b_sh),
    .acc_next  (acc_step),
    .a_sh_next (a_sh_step),
    .b_sh_next (b_sh_step)
  );

  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; outputs depend on state only.
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    busy_o     = 1'b0;
    accept     = 1'b0;
    case (state)
      MUL_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          accept     = 1'b1;
          state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        busy_o = 1'b1;
        if (last_iter) begin
          state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_next = MUL_IDLE;
        end
      end
      default: begin
        state_next = MUL_IDLE;
      end
    endcase
  end

  // Datapath registers: load on acceptance, step every RUN cycle, hold
  // otherwise (acc stays visible on product_o after the operation).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (accept) begin
      acc  <= '0;
      a_sh <= DATA_LENGTH'(a_i);
      b_sh <= b_i;
      cnt  <= '0;
    end else if (state == MUL_RUN) begin
      acc  <= acc_step;
      a_sh <= a_sh_step;
      b_sh <= b_sh_step;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign product_o = acc;

endmodule

// File: tb/tb_shiftadd_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_shiftadd_mul_seq
//   Self-checking bench for shiftadd_mul_seq: table of directed operand
//   pairs with latency/stall checks, an asynchronous-reset abort, a
//   back-to-back sequence, and randomized traffic against a product queue.
//   Honors SHIFTADD_MUL_RADIX4_EN for the expected latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shiftadd_mul_seq;
  import multiplier_pkg::*;

  localparam int W  = 12;
  localparam int DL = DATA_LENGTH;
`ifdef SHIFTADD_MUL_RADIX4_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif
  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic          busy_o;
  logic [DL-1:0] product_o;

  always #5 clk_i = ~clk_i;

  shiftadd_mul_seq #(.OP_WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .busy_o    (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            stall;
    bit            poke;
    logic [DL-1:0] exp;
  } vec_t;

  // One full operation: offer operands, check latency, hold DONE for
  // 'stall' cycles (optionally poking valid_i), then complete the handshake.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit poke, input logic [DL-1:0] exp);
    int n;
    @(negedge clk_i);
    valid_i = 1'b1; a_i = a; b_i = b; ready_i = 1'b0;
    n = 0;
    while (!ready_o && n < TMO) begin @(negedge clk_i); n++; end
    chk({name, "_accept_ready"}, 64'(ready_o), 64'd1);
    @(negedge clk_i);
    valid_i = 1'b0; a_i = W'($urandom); b_i = W'($urandom);
    n = 1;
    chk({name, "_busy"}, 64'(busy_o), 64'd1);
    while (!valid_o && n < TMO) begin @(negedge clk_i); n++; end
    chk({name, "_latency"}, 64'(n), 64'(LAT + 1));
    chk({name, "_product"}, 64'(product_o), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 1) begin valid_i = 1'b1; a_i = 5; b_i = 5; end
      @(negedge clk_i);
      valid_i = 1'b0;
      chk({name, "_stall_valid"}, 64'(valid_o), 64'd1);
      chk({name, "_stall_product"}, 64'(product_o), 64'(exp));
      chk({name, "_stall_ready"}, 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk({name, "_after_valid"}, 64'(valid_o), 64'd0);
    chk({name, "_after_ready"}, 64'(ready_o), 64'd1);
  endtask

  vec_t vecs[5];

  // ---------------- scoreboard ----------------
  logic [DL-1:0] exp_q[$];

  initial begin
    int n;
    int accepted;
    int got;
    logic          prev_stall;
    logic [DL-1:0] prev_prod;
    logic [DL-1:0] e;

    vecs[0] = '{a: 12'd3328, b: 12'd3328, stall: 0, poke: 1'b0, exp: 32'd11075584};
    vecs[1] = '{a: 12'd0,    b: 12'd1234, stall: 0, poke: 1'b0, exp: 32'd0};
    vecs[2] = '{a: 12'd1234, b: 12'd0,    stall: 0, poke: 1'b0, exp: 32'd0};
    vecs[3] = '{a: 12'd4095, b: 12'd4095, stall: 5, poke: 1'b1, exp: 32'd16769025};
    vecs[4] = '{a: 12'd1,    b: 12'd1,    stall: 2, poke: 1'b0, exp: 32'd1};

    // reset state
    #2;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_product", 64'(product_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].stall,
             vecs[i].poke, vecs[i].exp);
    end

    // async reset in MUL iteration 5 aborts the operation
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 12'd3000; b_i = 12'd2999;
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 1;
    while (n < 5) begin @(negedge clk_i); n++; end
    #2 rst_i = 1'b1;
    #1;
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_product", 64'(product_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      @(negedge clk_i);
      if (valid_o) got++;
    end
    ready_i = 1'b0;
    chk("abort_no_valid", 64'(got), 64'd0);
    run_op("post_abort", 12'd17, 12'd19, 0, 1'b0, 32'd323);

    // back-to-back with valid_i held high
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 12'd1; b_i = 12'd4095; ready_i = 1'b1;
    chk("b2b_ready0", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    a_i = 12'd2048; b_i = 12'd2;
    n = 1;
    while (!valid_o && n < TMO) begin @(negedge clk_i); n++; end
    chk("b2b_lat1", 64'(n), 64'(LAT + 1));
    chk("b2b_prod1", 64'(product_o), 64'd4095);
    @(negedge clk_i);
    chk("b2b_ready1", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < TMO) begin @(negedge clk_i); n++; end
    chk("b2b_lat2", 64'(n), 64'(LAT + 1));
    chk("b2b_prod2", 64'(product_o), 64'd4096);
    @(negedge clk_i);
    ready_i = 1'b0;

    // randomized traffic; inputs change at negedge, handshakes are judged
    // from the values that will be present at the next rising edge
    accepted = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_prod = '0;
    n = 0;
    while ((accepted < 1000 || exp_q.size() != 0) && n < 60000) begin
      @(negedge clk_i);
      n++;
      valid_i = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      a_i = ($urandom_range(0, 9) == 0) ? {W{1'b1}} : W'($urandom_range(0, (1 << W) - 1));
      b_i = ($urandom_range(0, 9) == 0) ? {W{1'b1}} : W'($urandom_range(0, (1 << W) - 1));
      ready_i = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        chk("rnd_hold_valid", 64'(valid_o), 64'd1);
        chk("rnd_hold_product", 64'(product_o), 64'(prev_prod));
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(DL'(a_i) * DL'(b_i));
        accepted++;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_valid", 64'(valid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_product", 64'(product_o), 64'(e));
          got++;
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_prod  = product_o;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("rnd_all_accepted", 64'(accepted), 64'd1000);
    chk("rnd_all_drained", 64'(got), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
